// File: rtl/acc_seg_display_if.sv
// acc_seg_display_if: accumulator input bus and 7-segment display outputs
interface acc_seg_display_if;
  logic [5:0] acc_n;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       busy;
  modport master (output acc_n, input seg_n, an_n, busy);
  modport slave  (input acc_n, output seg_n, an_n, busy);
endinterface

// File: rtl/acc_seg_display.sv
// acc_seg_display: converts the active-low accumulator bus to a 2-digit multiplexed 7-segment display
// Define HEX_DISPLAY_EN to show the value as two hex digits instead of decimal (no double-dabble pass).
module acc_seg_display #(
  parameter int SCAN_DIV = 16,
  parameter int SCAN_W   = 8
) (
  input logic              clk,
  input logic              rst,
  acc_seg_display_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;
  logic [5:0]        acc_q;
  logic [5:0]        last_val;
  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [3:0]        ones;
  logic [3:0]        tens;
  logic [SCAN_W-1:0] scan_cnt;
  logic              sel;
  logic              last_slot;
  logic              tens_on;
  logic              busy_q;
  logic [6:0]        seg_q;
  logic [1:0]        an_q;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'h0: enc = 7'h40;
      4'h1: enc = 7'h79;
      4'h2: enc = 7'h24;
      4'h3: enc = 7'h30;
      4'h4: enc = 7'h19;
      4'h5: enc = 7'h12;
      4'h6: enc = 7'h02;
      4'h7: enc = 7'h78;
      4'h8: enc = 7'h00;
      4'h9: enc = 7'h10;
      4'hA: enc = 7'h08;
      4'hB: enc = 7'h03;
      4'hC: enc = 7'h46;
      4'hD: enc = 7'h21;
      4'hE: enc = 7'h06;
      default: enc = 7'h0E;
    endcase
  endfunction

  // Input capture, change detection and conversion state; busy tracks the state being entered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q    <= '0;
      last_val <= '0;
      state    <= IDLE;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= ~bus.acc_n;
      state    <= state_nx;
      busy_q   <= state_nx == SHIFT || state_nx == LATCH;
      last_val <= (state == IDLE) ? acc_q : last_val;
    end

`ifdef HEX_DISPLAY_EN
  // Hex display needs no conversion: a change goes straight to LATCH
  always_comb
    state_nx = (state == IDLE && acc_q != last_val) ? LATCH : IDLE;

  // Digit registers take the nibbles of the captured value
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ones <= '0;
      tens <= '0;
    end else if (state == LATCH) begin
      tens <= {2'b00, last_val[5:4]};
      ones <= last_val[3:0];
    end
`else
  logic [13:0] sh;
  logic [2:0]  bit_cnt;
  logic [7:0]  bcd_adj;

  assign bcd_adj = {(sh[13:10] >= 4'd5) ? sh[13:10] + 4'd3 : sh[13:10],
                    (sh[9:6]   >= 4'd5) ? sh[9:6]   + 4'd3 : sh[9:6]};

  // Six shift cycles convert the 6-bit value, then one cycle latches the digits
  always_comb
    state_nx = (state == IDLE)  ? ((acc_q != last_val) ? SHIFT : IDLE) :
               (state == SHIFT) ? ((bit_cnt == 3'd5) ? LATCH : SHIFT) : IDLE;

  // Double-dabble shifter {bcd[7:0], bin[5:0]}; loaded every idle cycle, digits written in LATCH
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh      <= '0;
      bit_cnt <= '0;
      ones    <= '0;
      tens    <= '0;
    end else if (state == IDLE) begin
      sh      <= {8'd0, acc_q};
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      sh      <= {bcd_adj, sh[5:0]} << 1;
      bit_cnt <= bit_cnt + 3'd1;
    end else begin
      tens <= sh[13:10];
      ones <= sh[9:6];
    end
`endif

  assign last_slot = scan_cnt == SCAN_W'(SCAN_DIV - 1);
  assign tens_on   = sel && tens != 4'd0;

  // Digit scan: last clock of each slot is dead to avoid ghosting; a zero tens digit is blanked
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scan_cnt <= '0;
      sel      <= 1'b0;
      an_q     <= 2'b11;
      seg_q    <= 7'h7F;
    end else begin
      scan_cnt <= last_slot ? '0 : scan_cnt + SCAN_W'(1);
      sel      <= sel ^ last_slot;
      an_q     <= last_slot ? 2'b11 : !sel ? 2'b10 : tens_on ? 2'b01 : 2'b11;
      seg_q    <= last_slot ? 7'h7F : !sel ? enc(ones) : tens_on ? enc(tens) : 7'h7F;
    end

  assign bus.seg_n = seg_q;
  assign bus.an_n  = an_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_acc_seg_display.sv
// tb_acc_seg_display: directed checks of conversion, busy timing, blanking and digit scan
module tb_acc_seg_display;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   n = 0;
  int   bc;

  always #5 clk = ~clk;

  acc_seg_display_if bus ();
  acc_seg_display #(.SCAN_DIV(4), .SCAN_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef HEX_DISPLAY_EN
  localparam int         BL  = 1;
  localparam logic [6:0] O37 = 7'h12, T37 = 7'h24;
  localparam logic [6:0] O63 = 7'h0E, T63 = 7'h30;
  localparam logic [6:0] O45 = 7'h21, T45 = 7'h24;
  localparam logic [6:0] O42 = 7'h08, T42 = 7'h24;
`else
  localparam int         BL  = 7;
  localparam logic [6:0] O37 = 7'h78, T37 = 7'h30;
  localparam logic [6:0] O63 = 7'h30, T63 = 7'h02;
  localparam logic [6:0] O45 = 7'h12, T45 = 7'h19;
  localparam logic [6:0] O42 = 7'h24, T42 = 7'h19;
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic put(input logic [5:0] v);
    bus.acc_n = ~v;
  endtask

  task automatic run_busy(inout int c, input int cyc);
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (bus.busy === 1'b1) c++;
    end
  endtask

  task automatic scan(input string tag, input logic [6:0] os, input logic [6:0] ts, input int cyc);
    int p;
    logic [8:0] e;
    for (int i = 0; i < cyc; i++) begin
      tick();
      p = (n - 1) % 8;
      e = (p < 3) ? {2'b10, os} :
          (p == 3 || p == 7 || ts == 7'h7F) ? {2'b11, 7'h7F} : {2'b01, ts};
      chk($sformatf("%s_c%0d", tag, i), {7'd0, bus.an_n, bus.seg_n}, {7'd0, e});
    end
  endtask

  initial begin
    rst = 1'b1;
    put(6'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    put(6'd37);
    tick();
    tick();
    chk("pre_busy", {15'd0, bus.busy}, 16'd1);
    chk("pre_disp", {7'd0, bus.an_n, bus.seg_n}, {7'd0, 2'b10, 7'h40});
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", {6'd0, bus.an_n, bus.seg_n, bus.busy}, {6'd0, 2'b11, 7'h7F, 1'b0});
    put(6'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    bc = 0;
    run_busy(bc, 16);
    chk("zero_busy", 16'(bc), 16'd0);
    scan("zero", 7'h40, 7'h7F, 16);

    put(6'd37);
    bc = 0;
    run_busy(bc, 20);
    chk("b37", 16'(bc), 16'(BL));
    scan("d37", O37, T37, 16);

    put(6'd63);
    bc = 0;
    run_busy(bc, 20);
    chk("b63", 16'(bc), 16'(BL));
    scan("d63", O63, T63, 16);

    put(6'd9);
    bc = 0;
    run_busy(bc, 20);
    chk("b9", 16'(bc), 16'(BL));
    scan("d9", 7'h10, 7'h7F, 16);

    put(6'd12);
    bc = 0;
    run_busy(bc, 2);
    put(6'd45);
    run_busy(bc, 40);
    chk("b12_45", 16'(bc), 16'(2 * BL));
    scan("d45", O45, T45, 16);

    put(6'd42);
    bc = 0;
    run_busy(bc, 20);
    chk("b42", 16'(bc), 16'(BL));
    scan("d42", O42, T42, 16);

    bc = 0;
    run_busy(bc, 12);
    chk("b42_same", 16'(bc), 16'd0);
    scan("d42_hold", O42, T42, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
